wb_write_arbiter: RTL and testbench

- Writeback-side producer for the register file's single write port (RegWriteW / WriteRegW / ResultW).
- Holds the MEM/WB pipeline register and the result select (ALU vs. memory).
- Merges a second write source from a multi-cycle long-latency unit (mul/div) through a small pending-write queue. The pipeline always owns the port; queued writes drain in idle slots.
- Exports a pending-register mask so the hazard unit can stall readers of registers whose values are still queued.

---
 rtl/wb_write_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_write_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Writeback-stage producer for the register-file write port: MEM/WB register plus a
// small FIFO of long-latency results that drain into idle port slots.
module wb_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RegWriteM,
    input  logic          MemtoRegM,
    input  logic [4:0]    WriteRegM,
    input  logic [31:0]   ALUOutM,
    input  logic [31:0]   ReadDataM,
    input  logic          LongValid,
    input  logic [4:0]    LongReg,
    input  logic [31:0]   LongData,
    output logic          LongReady,
    output logic          RegWriteW,
    output logic [4:0]    WriteRegW,
    output logic [31:0]   ResultW,
    output logic [31:0]   PendMask,
    output logic [AW:0]   QueueCount
);

    logic          wb_we_r;
    logic [4:0]    wb_reg_r;
    logic [31:0]   wb_data_r;
    logic          q_valid_r [DEPTH];
    logic [4:0]    q_reg_r   [DEPTH];
    logic [31:0]   q_data_r  [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW:0]   count_r;

    logic          pipe_active_s;
    logic          head_valid_s;
    logic          pop_s;
    logic          push_s;
    logic          push_killed_s;
    logic [31:0]   pend_s;

    // Pipeline owns the port whenever it writes a real register; $0 writes are suppressed.
    always_comb begin
        pipe_active_s = wb_we_r && (wb_reg_r != 5'd0);
        head_valid_s  = (count_r != {(AW+1){1'b0}}) && q_valid_r[rd_ptr_r];
        LongReady     = (count_r != (AW+1)'(DEPTH));
        pop_s         = (count_r != {(AW+1){1'b0}}) && (!q_valid_r[rd_ptr_r] || !pipe_active_s);
        push_s        = LongValid && LongReady && (LongReg != 5'd0);
        push_killed_s = pipe_active_s && (LongReg == wb_reg_r);
        QueueCount    = count_r;
    end

    // Register-file port mux: pipeline first, then a valid queue head, else quiet.
    always_comb begin
        RegWriteW = 1'b0;
        WriteRegW = 5'd0;
        ResultW   = 32'd0;
        if (pipe_active_s) begin
            RegWriteW = 1'b1;
            WriteRegW = wb_reg_r;
            ResultW   = wb_data_r;
        end else if (head_valid_s) begin
            RegWriteW = 1'b1;
            WriteRegW = q_reg_r[rd_ptr_r];
            ResultW   = q_data_r[rd_ptr_r];
        end else begin
            RegWriteW = 1'b0;
        end
    end

    // Pending mask: one bit per register still owed a write by a live queue entry.
    always_comb begin
        pend_s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid_r[i]) begin
                pend_s[q_reg_r[i]] = 1'b1;
            end else begin
                pend_s = pend_s;
            end
        end
        pend_s[0] = 1'b0;
        PendMask  = pend_s;
    end

    // MEM/WB pipeline register, no stall or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_r   <= 1'b0;
            wb_reg_r  <= 5'd0;
            wb_data_r <= 32'd0;
        end else begin
            wb_we_r   <= RegWriteM;
            wb_reg_r  <= WriteRegM;
            wb_data_r <= MemtoRegM ? ReadDataM : ALUOutM;
        end
    end

    // Pending-write FIFO: WAW kill, pop, push, then occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_valid_r[i] <= 1'b0;
                q_reg_r[i]   <= 5'd0;
                q_data_r[i]  <= 32'd0;
            end
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_active_s && q_valid_r[i] && (q_reg_r[i] == wb_reg_r)) begin
                    q_valid_r[i] <= 1'b0;
                end
            end
            if (pop_s) begin
                q_valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r            <= rd_ptr_r + AW'(1);
            end
            if (push_s) begin
                q_valid_r[wr_ptr_r] <= !push_killed_s;
                q_reg_r[wr_ptr_r]   <= LongReg;
                q_data_r[wr_ptr_r]  <= LongData;
                wr_ptr_r            <= wr_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: a queue-based reference model predicts every
// port write and per-cycle status; a negedge monitor compares them against the DUT.
module tb_wb_write_arbiter;

    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteM, MemtoRegM, LongValid;
    logic [4:0]  WriteRegM, LongReg;
    logic [31:0] ALUOutM, ReadDataM, LongData;
    logic        LongReady, RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW, PendMask;
    logic [AW:0] QueueCount;

    wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
        .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
        .LongValid(LongValid), .LongReg(LongReg), .LongData(LongData),
        .LongReady(LongReady), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
        .ResultW(ResultW), .PendMask(PendMask), .QueueCount(QueueCount)
    );

    always #5 clk = ~clk;

    typedef struct { logic v; logic [4:0] r; logic [31:0] d; } ent_t;
    typedef struct { logic [4:0] r; logic [31:0] d; } wr_t;
    typedef struct { logic we; logic [31:0] pm; logic [31:0] cnt; logic rdy; } st_t;

    // Reference model state: the W-stage latch and the pending-write list.
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic        m_acc;
    ent_t        mq[$];
    wr_t         exp_wr[$];
    st_t         st_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic active();
        return m_we && (m_reg != 5'd0);
    endfunction

    // One clock edge of the specified behaviour, then publish the expectations for the new state.
    task automatic model_step();
        logic  act;
        logic  do_pop;
        st_t   st;
        act    = active();
        m_acc  = LongValid && (mq.size() != DEPTH);
        do_pop = (mq.size() > 0) && (!mq[0].v || !act);
        if (act) begin
            foreach (mq[i]) if (mq[i].r == m_reg) mq[i].v = 1'b0;
        end
        if (do_pop) void'(mq.pop_front());
        if (m_acc && LongReg != 5'd0)
            mq.push_back('{v: !(act && LongReg == m_reg), r: LongReg, d: LongData});
        m_we   = RegWriteM;
        m_reg  = WriteRegM;
        m_data = MemtoRegM ? ReadDataM : ALUOutM;

        st.pm = 32'd0;
        foreach (mq[i]) if (mq[i].v) st.pm[mq[i].r] = 1'b1;
        st.cnt = 32'(mq.size());
        st.rdy = (mq.size() != DEPTH);
        st.we  = 1'b1;
        if (active())                       exp_wr.push_back('{r: m_reg, d: m_data});
        else if (mq.size() > 0 && mq[0].v)  exp_wr.push_back('{r: mq[0].r, d: mq[0].d});
        else                                st.we = 1'b0;
        st_q.push_back(st);
    endtask

    task automatic model_reset();
        m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0;
        mq.delete(); exp_wr.delete(); st_q.delete();
    endtask

    task automatic cyc(input logic rw, input logic mtr, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] rd,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        RegWriteM = rw; MemtoRegM = mtr; WriteRegM = wr; ALUOutM = alu; ReadDataM = rd;
        LongValid = lv; LongReg = lr; LongData = ld;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"},   32'(RegWriteW),  32'd0);
        chk({tag, "_reg"},  32'(WriteRegW),  32'd0);
        chk({tag, "_data"}, ResultW,         32'd0);
        chk({tag, "_pend"}, PendMask,        32'd0);
        chk({tag, "_cnt"},  32'(QueueCount), 32'd0);
    endtask

    // Monitor: every cycle compare status; whenever the DUT writes, pop the predicted write.
    always @(negedge clk) begin
        st_t st;
        wr_t w;
        if (rst_n && st_q.size() > 0) begin
            st = st_q.pop_front();
            chk("we",    32'(RegWriteW),  32'(st.we));
            chk("pend",  PendMask,        st.pm);
            chk("count", 32'(QueueCount), st.cnt);
            chk("ready", 32'(LongReady),  32'(st.rdy));
            if (RegWriteW) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_write: r%0d=0x%0h, expected no write", WriteRegW, ResultW);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_reg",  32'(WriteRegW), 32'(w.r));
                    chk("wr_data", ResultW,        w.d);
                end
            end else begin
                chk("idle_reg",  32'(WriteRegW), 32'd0);
                chk("idle_data", ResultW,        32'd0);
            end
        end
    end

    initial begin
        logic [4:0] longs [3];
        int k;
        longs[0] = 5'd3; longs[1] = 5'd4; longs[2] = 5'd6;
        rst_n = 1'b0;
        RegWriteM = 1'b0; MemtoRegM = 1'b0; WriteRegM = 5'd0; ALUOutM = 32'd0; ReadDataM = 32'd0;
        LongValid = 1'b0; LongReg = 5'd0; LongData = 32'd0;
        model_reset();
        #12;
        chk_zero("reset");
        #10 rst_n = 1'b1;
        #1 chk("reset_ready", 32'(LongReady), 32'd1);

        // Basic MEM/WB capture: ALU, load, and a suppressed $0 write.
        cyc(1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 1'b1, 5'd5, 32'h0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 1'b0, 5'd0, 32'h99, 32'h0, 1'b0, 5'd0, 32'd0);
        idle(2);

        // Long result into an idle pipeline drains the cycle after acceptance.
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd9, 32'hAAAA);
        idle(3);

        // Busy pipeline: queue fills, third offer held until a slot frees.
        k = 0;
        for (int c = 0; c < 16 && k < 3; c++) begin
            cyc((c < 6), 1'b0, 5'd20, 32'(c), 32'd0, 1'b1, longs[k], 32'h100 + 32'(k));
            if (m_acc) k++;
        end
        idle(4);

        // WAW kill of a queued entry by a later pipeline write.
        cyc(1'b1, 1'b0, 5'd12, 32'h12, 32'd0, 1'b1, 5'd7, 32'h77);
        cyc(1'b1, 1'b0, 5'd7, 32'h55, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(4);

        // Enqueue killed on arrival, then an enqueue to $0 that must vanish.
        cyc(1'b1, 1'b0, 5'd8, 32'h88, 32'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd8, 32'hBAD8);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'hBAD0);
        idle(4);

        // Randomized traffic over a narrow register range to provoke kills and repeats.
        for (int c = 0; c < 600; c++) begin
            cyc(($urandom_range(0, 99) < 55), $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                $urandom, $urandom,
                ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom);
        end
        idle(6);

        // Reset with two live entries queued behind a busy pipeline.
        cyc(1'b1, 1'b0, 5'd13, 32'h13, 32'd0, 1'b1, 5'd14, 32'h14);
        cyc(1'b1, 1'b0, 5'd13, 32'h13, 32'd0, 1'b1, 5'd15, 32'h15);
        chk("pre_reset_cnt", 32'(QueueCount), 32'd2);
        #1 rst_n = 1'b0;
        model_reset();
        #1 chk_zero("midreset");
        #5 rst_n = 1'b1;
        idle(5);
        @(negedge clk);
        #1;
        chk("writes_left", 32'(exp_wr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
